// File: rtl/chip_pkg.sv
// Shared edge-detection chip types: pixel width, image size, sorted column and
// the three-input median helper used by the median filter.
package chip_pkg;

    localparam int BIT_LENGTH = 5;
    localparam int IMG_DIM    = 20;
    localparam int COL_W      = 5;

    typedef logic [BIT_LENGTH-1:0] pix_t;
    typedef logic [COL_W-1:0]      col_idx_t;

    // One window column after the entry sort, smallest value first.
    typedef struct packed {
        pix_t lo;
        pix_t mid;
        pix_t hi;
    } col_t;

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        pix_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        pix_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        pix_t lo_ab;
        pix_t hi_ab;
        pix_t lo_rest;
        lo_ab   = (a < b) ? a : b;
        hi_ab   = (a < b) ? b : a;
        lo_rest = (hi_ab < c) ? hi_ab : c;
        return (lo_ab > lo_rest) ? lo_ab : lo_rest;
    endfunction

endpackage

// File: rtl/sort3.sv
// Combinational three-input unsigned sorter; used for the incoming column and
// again for the final median-of-three.
module sort3 #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] mid_o,
    output logic [W-1:0] hi_o
);

    logic [W-1:0] ab_lo;
    logic [W-1:0] ab_hi;
    logic [W-1:0] rest;

    always_comb begin
        ab_lo = (a_i < b_i) ? a_i : b_i;
        ab_hi = (a_i < b_i) ? b_i : a_i;
        hi_o  = (ab_hi < c_i) ? c_i : ab_hi;
        // Whatever did not become the maximum still has to be ordered against ab_lo.
        rest  = (ab_hi < c_i) ? ab_hi : c_i;
        lo_o  = (ab_lo < rest) ? ab_lo : rest;
        mid_o = (ab_lo < rest) ? rest : ab_lo;
    end

endmodule

// File: rtl/med_fil.sv
// Streaming 3x3 median filter over a sliding three-column window.
// Define MED_FIL_PIPE_EN to register the three-way reduction (2-cycle latency).
module med_fil
    import chip_pkg::*;
#(
    parameter int BIT_LENGTH = chip_pkg::BIT_LENGTH,
    parameter int IMG_DIM    = chip_pkg::IMG_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    // enable is a valid-only strobe: there is no ready, every enabled column is consumed.
    input  logic                  enable,
    input  logic                  row_start,
    input  logic [BIT_LENGTH-1:0] in3_0,
    input  logic [BIT_LENGTH-1:0] in3_1,
    input  logic [BIT_LENGTH-1:0] in3_2,
    output logic [BIT_LENGTH-1:0] med_out,
    output logic                  readable,
    output logic [4:0]            out_col
);

    localparam col_idx_t OC_MAX = col_idx_t'(IMG_DIM - 3);

    // Entry sort of the incoming column
    pix_t new_lo;
    pix_t new_mid;
    pix_t new_hi;
    col_t new_col;

    sort3 #(.W(BIT_LENGTH)) u_sort_in (
        .a_i   (in3_0),
        .b_i   (in3_1),
        .c_i   (in3_2),
        .lo_o  (new_lo),
        .mid_o (new_mid),
        .hi_o  (new_hi)
    );

    assign new_col = '{lo: new_lo, mid: new_mid, hi: new_hi};

    // The oldest column (w0) is only ever combined as w1 is shifted out, so the
    // registered window holds w1/w2 and the arriving column plays the role of w2.
    col_t     w1_q;
    col_t     w1_d;
    col_t     w2_q;
    col_t     w2_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    col_idx_t oc_q;
    col_idx_t oc_d;
    logic     fire;

    assign fire = enable & ~row_start & (cnt_q >= 2'd2);

    always_comb begin
        w1_d  = w1_q;
        w2_d  = w2_q;
        cnt_d = cnt_q;
        if (row_start && enable) begin
            w1_d  = '0;
            w2_d  = new_col;
            cnt_d = 2'd1;
        end else if (row_start) begin
            w1_d  = '0;
            w2_d  = '0;
            cnt_d = 2'd0;
        end else if (enable) begin
            w1_d  = w2_q;
            w2_d  = new_col;
            cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
        end
    end

    always_comb begin
        oc_d = oc_q;
        if (row_start) begin
            oc_d = '0;
        end else if (fire && (oc_q != OC_MAX)) begin
            oc_d = oc_q + col_idx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w1_q  <= '0;
            w2_q  <= '0;
            cnt_q <= 2'd0;
            oc_q  <= '0;
        end else begin
            w1_q  <= w1_d;
            w2_q  <= w2_d;
            cnt_q <= cnt_d;
            oc_q  <= oc_d;
        end
    end

    // Three-way reduction over the window that includes the arriving column
    pix_t red_lo;
    pix_t red_mid;
    pix_t red_hi;

    always_comb begin
        red_lo  = max3(w1_q.lo,  w2_q.lo,  new_col.lo);
        red_mid = med3(w1_q.mid, w2_q.mid, new_col.mid);
        red_hi  = min3(w1_q.hi,  w2_q.hi,  new_col.hi);
    end

    pix_t     fin_a;
    pix_t     fin_b;
    pix_t     fin_c;
    logic     fin_vld;
    col_idx_t fin_col;

`ifdef MED_FIL_PIPE_EN
    pix_t     s1_lo_q;
    pix_t     s1_mid_q;
    pix_t     s1_hi_q;
    logic     s1_vld_q;
    col_idx_t s1_col_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_lo_q  <= '0;
            s1_mid_q <= '0;
            s1_hi_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_col_q <= '0;
        end else begin
            s1_vld_q <= fire;
            if (fire) begin
                s1_lo_q  <= red_lo;
                s1_mid_q <= red_mid;
                s1_hi_q  <= red_hi;
                s1_col_q <= oc_q;
            end
        end
    end

    assign fin_a   = s1_lo_q;
    assign fin_b   = s1_mid_q;
    assign fin_c   = s1_hi_q;
    assign fin_vld = s1_vld_q;
    assign fin_col = s1_col_q;
`else
    assign fin_a   = red_lo;
    assign fin_b   = red_mid;
    assign fin_c   = red_hi;
    assign fin_vld = fire;
    assign fin_col = oc_q;
`endif

    // Only the middle of the final sort is the median; the extremes are discarded.
    pix_t fin_lo_unused;
    pix_t fin_mid;
    pix_t fin_hi_unused;

    sort3 #(.W(BIT_LENGTH)) u_sort_fin (
        .a_i   (fin_a),
        .b_i   (fin_b),
        .c_i   (fin_c),
        .lo_o  (fin_lo_unused),
        .mid_o (fin_mid),
        .hi_o  (fin_hi_unused)
    );

    pix_t     med_q;
    pix_t     med_d;
    logic     rd_q;
    col_idx_t col_q;
    col_idx_t col_d;

    always_comb begin
        med_d = med_q;
        col_d = col_q;
        if (fin_vld) begin
            med_d = fin_mid;
            col_d = fin_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            med_q <= '0;
            rd_q  <= 1'b0;
            col_q <= '0;
        end else begin
            med_q <= med_d;
            rd_q  <= fin_vld;
            col_q <= col_d;
        end
    end

    assign med_out  = med_q;
    assign readable = rd_q;
    assign out_col  = col_q;

endmodule

// File: tb/tb_med_fil.sv
// Directed table-driven bench for med_fil; follows MED_FIL_PIPE_EN for latency.
module tb_med_fil;

`ifdef MED_FIL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       row_start;
    logic [4:0] in3_0;
    logic [4:0] in3_1;
    logic [4:0] in3_2;
    logic [4:0] med_out;
    logic       readable;
    logic [4:0] out_col;

    med_fil #(.BIT_LENGTH(5), .IMG_DIM(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .row_start (row_start),
        .in3_0     (in3_0),
        .in3_1     (in3_1),
        .in3_2     (in3_2),
        .med_out   (med_out),
        .readable  (readable),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         rs;
        bit         en;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] c;
        bit         er;
        logic [4:0] em;
        logic [4:0] ec;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic void add_vec(bit rst, bit rs, bit en, int a, int b, int c,
                                    bit er, int em, int ec);
        vec_t v;
        v.rst = rst; v.rs = rs; v.en = en;
        v.a = 5'(a); v.b = 5'(b); v.c = 5'(c);
        v.er = er; v.em = 5'(em); v.ec = 5'(ec);
        vecs.push_back(v);
    endfunction

    function automatic void add_col(bit rs, int a, int b, int c, bit er, int em, int ec);
        add_vec(1'b0, rs, 1'b1, a, b, c, er, em, ec);
    endfunction

    function automatic void add_idle(int n);
        for (int k = 0; k < n; k++) add_vec(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    endfunction

    task automatic check(input string name, input int idx, input logic [4:0] act,
                         input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic fill_latency();
        exp_q.delete();
        for (int k = 0; k < LAT - 1; k++) exp_q.push_back('0);
    endtask

    initial begin
        logic [18:0] e;

        reset = 1'b1; enable = 1'b0; row_start = 1'b0;
        in3_0 = '0; in3_1 = '0; in3_2 = '0;

        // basic 1..9 window
        add_col(1, 1, 2, 3, 0, 0, 0);
        add_col(0, 4, 5, 6, 0, 0, 0);
        add_col(0, 7, 8, 9, 1, 5, 0);
        add_idle(2);
        // full row of (31,0,15) plus one column past the end
        add_col(1, 31, 0, 15, 0, 0, 0);
        add_col(0, 31, 0, 15, 0, 0, 0);
        for (int j = 3; j <= 21; j++) add_col(0, 31, 0, 15, 1, 15, (j - 3 > 17) ? 17 : j - 3);
        add_idle(1);
        // alternating 9/0 columns
        add_col(1, 9, 9, 9, 0, 0, 0);
        add_col(0, 0, 0, 0, 0, 0, 0);
        add_col(0, 9, 9, 9, 1, 9, 0);
        add_col(0, 0, 0, 0, 1, 0, 1);
        add_idle(1);
        // mixed values, true 9-pixel medians 12 then 14
        add_col(1, 3, 17, 9, 0, 0, 0);
        add_col(0, 25, 1, 12, 0, 0, 0);
        add_col(0, 8, 30, 20, 1, 12, 0);
        add_col(0, 2, 26, 14, 1, 14, 1);
        add_idle(1);
        // row_start after two columns restarts the window
        add_col(1, 7, 7, 7, 0, 0, 0);
        add_col(0, 7, 7, 7, 0, 0, 0);
        add_col(1, 2, 2, 2, 0, 0, 0);
        add_col(0, 2, 2, 2, 0, 0, 0);
        add_col(0, 2, 2, 2, 1, 2, 0);
        add_idle(1);
        // row_start right behind a qualifying column must not cancel it
        add_col(1, 4, 4, 4, 0, 0, 0);
        add_col(0, 4, 4, 4, 0, 0, 0);
        add_col(0, 4, 4, 4, 1, 4, 0);
        add_col(1, 6, 6, 6, 0, 0, 0);
        add_idle(1);
        // reset (with enable) the cycle after a qualifying column
        add_col(1, 1, 1, 1, 0, 0, 0);
        add_col(0, 1, 1, 1, 0, 0, 0);
        add_col(0, 1, 1, 1, LAT == 1, 1, 0);
        add_vec(1'b1, 1'b0, 1'b1, 1, 1, 1, 0, 0, 0);
        add_col(0, 5, 5, 5, 0, 0, 0);
        add_col(0, 5, 5, 5, 0, 0, 0);
        add_col(0, 5, 5, 5, 1, 5, 0);
        add_idle(1);
        // row_start without enable, then columns separated by 3 idle cycles
        add_vec(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        add_col(0, 31, 0, 31, 0, 0, 0);
        add_idle(3);
        add_col(0, 0, 31, 0, 0, 0, 0);
        add_idle(3);
        add_col(0, 31, 31, 0, 1, 31, 0);
        add_idle(3);
        add_col(0, 0, 0, 31, 1, 0, 1);
        add_idle(3);
        add_col(0, 31, 31, 31, 1, 31, 2);
        add_idle(3);

        repeat (2) @(posedge clk);
        #1;
        check("reset_readable", -1, 5'(readable), 5'd0);
        check("reset_med_out", -1, med_out, 5'd0);
        check("reset_out_col", -1, out_col, 5'd0);
        reset = 1'b0;
        fill_latency();

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            row_start = vecs[i].rs;
            enable    = vecs[i].en;
            in3_0     = vecs[i].a;
            in3_1     = vecs[i].b;
            in3_2     = vecs[i].c;
            @(posedge clk);
            #1;
            if (vecs[i].rst) begin
                check("rst_readable", i, 5'(readable), 5'd0);
                check("rst_med_out", i, med_out, 5'd0);
                check("rst_out_col", i, out_col, 5'd0);
                fill_latency();
            end else begin
                exp_q.push_back({i[7:0], vecs[i].er, vecs[i].em, vecs[i].ec});
                e = exp_q.pop_front();
                check("readable", int'(e[18:11]), 5'(readable), 5'(e[10]));
                if (e[10]) begin
                    check("med_out", int'(e[18:11]), med_out, e[9:5]);
                    check("out_col", int'(e[18:11]), out_col, e[4:0]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
